// File: rtl/lighthouse_pulse_decoder.sv
// Lighthouse v1 per-sensor pulse decoder: classifies envelope pulses as sync or
// sweep by width, decodes sync codes and times sweeps into a packed sensor word.
module lighthouse_pulse_decoder #(
  parameter int unsigned SENSOR_ID       = 0,
  parameter int unsigned CLK_SPEED       = 16_000_000,
  parameter int unsigned MIN_PULSE_US    = 2,
  parameter int unsigned SWEEP_MAX_US    = 50,
  parameter int unsigned PAIR_WINDOW_US  = 400,
  parameter int unsigned SYNC_TIMEOUT_US = 20000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        sensor_i,
  output logic [31:0] data_o,
  output logic        sync_o,
  output logic        data_bit_o
);

  localparam int unsigned TPU       = CLK_SPEED / 1_000_000;
  localparam int unsigned TMO_TICKS = SYNC_TIMEOUT_US * TPU;
  localparam int unsigned TMO_W     = $clog2(TMO_TICKS + 1);

  localparam logic [13:0] WIDTH_MAX = 14'h3FFF;
  localparam logic [13:0] MIN_T     = 14'(MIN_PULSE_US * TPU);
  localparam logic [13:0] SWEEP_T   = 14'(SWEEP_MAX_US * TPU);
  localparam logic [13:0] SYNC_LO   = 14'(57 * TPU);
  localparam logic [13:0] SYNC_HI   = 14'(140 * TPU);

  // Sync code thresholds: TPU*(677+104k)/10, folded at elaboration time.
  localparam logic [13:0] TH0 = 14'((TPU * (677 + 104 * 0)) / 10);
  localparam logic [13:0] TH1 = 14'((TPU * (677 + 104 * 1)) / 10);
  localparam logic [13:0] TH2 = 14'((TPU * (677 + 104 * 2)) / 10);
  localparam logic [13:0] TH3 = 14'((TPU * (677 + 104 * 3)) / 10);
  localparam logic [13:0] TH4 = 14'((TPU * (677 + 104 * 4)) / 10);
  localparam logic [13:0] TH5 = 14'((TPU * (677 + 104 * 5)) / 10);
  localparam logic [13:0] TH6 = 14'((TPU * (677 + 104 * 6)) / 10);

  localparam logic [19:0]      PAIR_T = 20'(PAIR_WINDOW_US * TPU);
  localparam logic [TMO_W-1:0] TMO_T  = TMO_W'(TMO_TICKS);
  localparam logic [9:0]       SID    = 10'(SENSOR_ID);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_CLASSIFY
  } state_t;

  function automatic logic [13:0] width_inc(input logic [13:0] w);
    return (w == WIDTH_MAX) ? w : w + 14'd1;
  endfunction

  function automatic logic [TMO_W-1:0] age_inc(input logic [TMO_W-1:0] t);
    return (t == TMO_T) ? t : t + TMO_W'(1);
  endfunction

  function automatic logic [18:0] sat19(input logic [20:0] v);
    return (v[20:19] != 2'b00) ? 19'h7FFFF : v[18:0];
  endfunction

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q, prev_q;
  logic [19:0]      now_q;
  logic [19:0]      rise_t_q, rise_t_d;
  logic [13:0]      width_q, width_d;
  logic [19:0]      sweep_start_q, sweep_start_d;
  logic             axis_q, axis_d;
  logic             lh_q, lh_d;
  logic             active_q, active_d;
  logic [19:0]      prev_rise_q, prev_rise_d;
  logic             prev_seen_q, prev_seen_d;
  logic [TMO_W-1:0] age_q, age_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [31:0]      data_q, data_d;
  logic             strobe_q, strobe_d;
  logic             dbit_q, dbit_d;

  logic        rise, fall;
  logic        is_sync, is_sweep, lh_now;
  logic [2:0]  code;
  logic [19:0] pair_dt, sweep_dt;
  logic [18:0] dur;

  assign rise = sync2_q & ~prev_q;
  assign fall = ~sync2_q & prev_q;

  assign is_sync  = (width_q >= SYNC_LO) && (width_q <= SYNC_HI);
  assign is_sweep = (width_q >= MIN_T) && (width_q <= SWEEP_T);

  assign code = 3'(width_q >= TH0) + 3'(width_q >= TH1) + 3'(width_q >= TH2)
              + 3'(width_q >= TH3) + 3'(width_q >= TH4) + 3'(width_q >= TH5)
              + 3'(width_q >= TH6);

  // Differences wrap with the free-running counter; the age check guards aliasing.
  assign pair_dt  = rise_t_q - prev_rise_q;
  assign sweep_dt = rise_t_q - sweep_start_q;
  assign dur      = sat19({1'b0, sweep_dt} + {8'b0, width_q[13:1]});
  assign lh_now   = prev_seen_q && (pair_dt < PAIR_T) && (age_q < TMO_T);

  always_comb begin
    state_d       = state_q;
    rise_t_d      = rise_t_q;
    width_d       = width_q;
    sweep_start_d = sweep_start_q;
    axis_d        = axis_q;
    lh_d          = lh_q;
    active_d      = active_q;
    prev_rise_d   = prev_rise_q;
    prev_seen_d   = prev_seen_q;
    age_d         = age_inc(age_q);
    tmo_d         = age_inc(tmo_q);
    data_d        = data_q;
    strobe_d      = 1'b0;
    dbit_d        = dbit_q;

    case (state_q)
      S_IDLE: begin
        if (rise) begin
          rise_t_d = now_q;
          width_d  = 14'd0;
          state_d  = S_HIGH;
        end
      end
      S_HIGH: begin
        width_d = width_inc(width_q);
        if (fall) begin
          state_d = S_CLASSIFY;
        end
      end
      S_CLASSIFY: begin
        state_d = S_IDLE;
        if (rise) begin
          rise_t_d = now_q;
          width_d  = 14'd0;
          state_d  = S_HIGH;
        end
        if (is_sync) begin
          prev_rise_d = rise_t_q;
          prev_seen_d = 1'b1;
          age_d       = '0;
          if (!code[2]) begin
            sweep_start_d = rise_t_q;
            axis_d        = code[0];
            lh_d          = lh_now;
            active_d      = 1'b1;
            dbit_d        = code[1];
            strobe_d      = 1'b1;
            tmo_d         = '0;
          end
        end else if (is_sweep && active_q) begin
          data_d = {dur, 1'b1, axis_q, lh_q, SID};
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Timeout wins over a sweep landing on the same edge.
    if (tmo_d == TMO_T) begin
      active_d   = 1'b0;
      data_d[12] = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Input chain resets high so a pulse already present at release is not seen as a rise.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      prev_q        <= 1'b1;
      now_q         <= 20'd0;
      rise_t_q      <= 20'd0;
      width_q       <= 14'd0;
      sweep_start_q <= 20'd0;
      axis_q        <= 1'b0;
      lh_q          <= 1'b0;
      active_q      <= 1'b0;
      prev_rise_q   <= 20'd0;
      prev_seen_q   <= 1'b0;
      age_q         <= '0;
      tmo_q         <= '0;
      data_q        <= {22'b0, SID};
      strobe_q      <= 1'b0;
      dbit_q        <= 1'b0;
    end else begin
      sync1_q       <= sensor_i;
      sync2_q       <= sync1_q;
      prev_q        <= sync2_q;
      now_q         <= now_q + 20'd1;
      rise_t_q      <= rise_t_d;
      width_q       <= width_d;
      sweep_start_q <= sweep_start_d;
      axis_q        <= axis_d;
      lh_q          <= lh_d;
      active_q      <= active_d;
      prev_rise_q   <= prev_rise_d;
      prev_seen_q   <= prev_seen_d;
      age_q         <= age_d;
      tmo_q         <= tmo_d;
      data_q        <= data_d;
      strobe_q      <= strobe_d;
      dbit_q        <= dbit_d;
    end
  end

  assign data_o     = data_q;
  assign sync_o     = strobe_q;
  assign data_bit_o = dbit_q;

endmodule
